// File: rtl/sprite_mem_arbiter.sv
// rtl/sprite_mem_arbiter.sv - sprite memory arbiter: video priority, round-robin aux with burst lock
// Optional macro SPRITE_ARB_BLANK_ONLY_EN restricts aux grants to blanking (video_enable=0).
module sprite_mem_arbiter #(
  parameter int NUM_AUX = 2,
  parameter int ELEM_W  = 3,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 12,
  parameter int MEM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      video_enable,
  input  logic                      vid_req,
  input  logic [ELEM_W-1:0]         vid_element,
  input  logic [ADDR_W-1:0]         vid_address,
  output logic                      vid_valid,
  output logic [DATA_W-1:0]         vid_data,
  input  logic [NUM_AUX-1:0]        aux_req,
  input  logic [NUM_AUX-1:0]        aux_lock,
  input  logic [NUM_AUX*ELEM_W-1:0] aux_element,
  input  logic [NUM_AUX*ADDR_W-1:0] aux_address,
  output logic [NUM_AUX-1:0]        aux_gnt,
  output logic [NUM_AUX-1:0]        aux_valid,
  output logic [DATA_W-1:0]         aux_data,
  output logic                      mem_read_enable,
  output logic [ELEM_W-1:0]         mem_element,
  output logic [ADDR_W-1:0]         mem_address,
  input  logic [DATA_W-1:0]         mem_dataout
);

  localparam int PTR_W = (NUM_AUX > 1) ? $clog2(NUM_AUX) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_next;
  logic [PTR_W-1:0] owner, owner_next;
  logic [PTR_W-1:0] sel, cand;
  logic             found;
  logic             aux_ok;
  logic             aux_accept;
  logic             vid_accept;
  int               idx;

  // Return-path tags travel with each read so data is steered to its issuer.
  logic             tag_vid [0:MEM_LAT];
  logic             tag_aux [0:MEM_LAT];
  logic [PTR_W-1:0] tag_idx [0:MEM_LAT];

  assign vid_accept = vid_req && !reset;

`ifdef SPRITE_ARB_BLANK_ONLY_EN
  assign aux_ok = !reset && !vid_req && !video_enable;
`else
  logic unused_video_enable;
  assign unused_video_enable = video_enable;
  assign aux_ok = !reset && !vid_req;
`endif

  always_comb begin
    state_next  = state;
    rr_ptr_next = rr_ptr;
    owner_next  = owner;
    aux_gnt     = '0;
    aux_accept  = 1'b0;
    sel         = owner;
    cand        = '0;
    found       = 1'b0;
    idx         = 0;
    if (state == IDLE) begin
      for (int i = 0; i < NUM_AUX; i++) begin
        idx = int'(rr_ptr) + i;
        if (idx >= NUM_AUX) idx = idx - NUM_AUX;
        cand = PTR_W'(idx);
        if (!found && aux_req[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
      if (aux_ok && found) begin
        aux_accept  = 1'b1;
        rr_ptr_next = (int'(sel) == NUM_AUX - 1) ? '0 : sel + 1'b1;
        if (aux_lock[sel]) begin
          state_next = BURST;
          owner_next = sel;
        end
      end
    end else begin
      // Burst is frozen on cycles where aux may not be served (video or active area).
      if (aux_ok) begin
        if (aux_req[owner]) begin
          aux_accept = 1'b1;
          if (!aux_lock[owner]) state_next = IDLE;
        end else begin
          state_next = IDLE;
        end
      end
    end
    if (aux_accept) aux_gnt[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      owner           <= '0;
      mem_read_enable <= 1'b0;
      mem_element     <= '0;
      mem_address     <= '0;
      for (int s = 0; s <= MEM_LAT; s++) begin
        tag_vid[s] <= 1'b0;
        tag_aux[s] <= 1'b0;
        tag_idx[s] <= '0;
      end
    end else begin
      state  <= state_next;
      rr_ptr <= rr_ptr_next;
      owner  <= owner_next;
      if (vid_accept) begin
        mem_read_enable <= 1'b1;
        mem_element     <= vid_element;
        mem_address     <= vid_address;
      end else if (aux_accept) begin
        mem_read_enable <= 1'b1;
        mem_element     <= aux_element[int'(sel)*ELEM_W +: ELEM_W];
        mem_address     <= aux_address[int'(sel)*ADDR_W +: ADDR_W];
      end else begin
        mem_read_enable <= 1'b0;
      end
      tag_vid[0] <= vid_accept;
      tag_aux[0] <= aux_accept;
      tag_idx[0] <= sel;
      for (int s = 1; s <= MEM_LAT; s++) begin
        tag_vid[s] <= tag_vid[s-1];
        tag_aux[s] <= tag_aux[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end
    end
  end

  assign vid_valid = tag_vid[MEM_LAT] && !reset;
  assign vid_data  = vid_valid ? mem_dataout : '0;

  always_comb begin
    aux_valid = '0;
    if (tag_aux[MEM_LAT] && !reset) aux_valid[tag_idx[MEM_LAT]] = 1'b1;
  end

  assign aux_data = (|aux_valid) ? mem_dataout : '0;

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// tb/tb_sprite_mem_arbiter.sv - directed bench for sprite_mem_arbiter with a one-cycle memory model
module tb_sprite_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        video_enable;
  logic        vid_req;
  logic [2:0]  vid_element;
  logic [9:0]  vid_address;
  logic        vid_valid;
  logic [11:0] vid_data;
  logic [1:0]  aux_req;
  logic [1:0]  aux_lock;
  logic [5:0]  aux_element;
  logic [19:0] aux_address;
  logic [1:0]  aux_gnt;
  logic [1:0]  aux_valid;
  logic [11:0] aux_data;
  logic        mem_read_enable;
  logic [2:0]  mem_element;
  logic [9:0]  mem_address;
  logic [11:0] mem_dataout = '0;

  always #5 clk = ~clk;

  sprite_mem_arbiter dut (
    .clk(clk), .reset(reset), .video_enable(video_enable),
    .vid_req(vid_req), .vid_element(vid_element), .vid_address(vid_address),
    .vid_valid(vid_valid), .vid_data(vid_data),
    .aux_req(aux_req), .aux_lock(aux_lock), .aux_element(aux_element),
    .aux_address(aux_address), .aux_gnt(aux_gnt), .aux_valid(aux_valid),
    .aux_data(aux_data), .mem_read_enable(mem_read_enable),
    .mem_element(mem_element), .mem_address(mem_address), .mem_dataout(mem_dataout)
  );

  function automatic logic [11:0] dexp(input logic [2:0] e, input logic [9:0] a);
    return {e, a[8:0]};
  endfunction

  always @(posedge clk) if (mem_read_enable) mem_dataout <= dexp(mem_element, mem_address);

  typedef struct {
    logic       v;
    logic [9:0] va;
    logic [1:0] req;
    logic [1:0] lock;
    logic       ven;
    logic [1:0] gnt;
  } row_t;

  typedef struct {
    logic       acc;
    logic       vid;
    logic       idx;
    logic [2:0] elem;
    logic [9:0] addr;
  } acc_t;

  int          checks = 0;
  int          failures = 0;
  row_t        rows[$];
  logic [2:0]  ae [2];
  logic [9:0]  aa [2];
  logic [2:0]  last_elem;
  logic [9:0]  last_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic [9:0] va, input logic [1:0] req,
                     input logic [1:0] lock, input logic ven, input logic [1:0] gnt);
    row_t r;
    r.v = v; r.va = va; r.req = req; r.lock = lock; r.ven = ven; r.gnt = gnt;
    rows.push_back(r);
  endtask

  task automatic check_zero(input string name);
    check({name, " read_en"}, mem_read_enable, 0);
    check({name, " mem_addr"}, mem_address, 0);
    check({name, " mem_elem"}, mem_element, 0);
    check({name, " vid_valid"}, vid_valid, 0);
    check({name, " vid_data"}, vid_data, 0);
    check({name, " aux_gnt"}, aux_gnt, 0);
    check({name, " aux_valid"}, aux_valid, 0);
    check({name, " aux_data"}, aux_data, 0);
  endtask

  // Drives the queued rows plus two idle cycles, checking grant, issue and return per cycle.
  task automatic run(input string name);
    acc_t p1, p2, cur;
    row_t rw;
    string t;
    p1 = '{default: '0};
    p2 = '{default: '0};
    for (int r = 0; r < rows.size() + 2; r++) begin
      if (r < rows.size()) rw = rows[r];
      else rw = '{default: '0};
      step();
      vid_req = rw.v; vid_address = rw.va; aux_req = rw.req;
      aux_lock = rw.lock; video_enable = rw.ven;
      #1;
      t = $sformatf("%s[%0d]", name, r);
      check({t, " gnt"}, aux_gnt, rw.gnt);
      check({t, " read_en"}, mem_read_enable, p1.acc);
      if (p1.acc) begin
        last_addr = p1.addr;
        last_elem = p1.elem;
      end
      check({t, " mem_addr"}, mem_address, last_addr);
      check({t, " mem_elem"}, mem_element, last_elem);
      check({t, " vid_valid"}, vid_valid, p2.acc && p2.vid);
      check({t, " vid_data"}, vid_data, (p2.acc && p2.vid) ? dexp(p2.elem, p2.addr) : 12'h0);
      check({t, " aux_valid"}, aux_valid, (p2.acc && !p2.vid) ? (2'b01 << p2.idx) : 2'b00);
      check({t, " aux_data"}, aux_data, (p2.acc && !p2.vid) ? dexp(p2.elem, p2.addr) : 12'h0);
      cur.vid = rw.v;
      cur.acc = rw.v || (rw.gnt != 2'b00);
      cur.idx = rw.gnt[1];
      cur.elem = rw.v ? vid_element : ae[rw.gnt[1]];
      cur.addr = rw.v ? rw.va : aa[rw.gnt[1]];
      p2 = p1;
      p1 = cur;
    end
    rows.delete();
  endtask

  initial begin
    ae[0] = 3'd1; ae[1] = 3'd2;
    aa[0] = 10'h0A5; aa[1] = 10'h15A;
    aux_element = {ae[1], ae[0]};
    aux_address = {aa[1], aa[0]};
    reset = 1'b1; video_enable = 1'b0; vid_req = 1'b0;
    vid_element = 3'd5; vid_address = '0; aux_req = '0; aux_lock = '0;
    last_elem = '0; last_addr = '0;
    step();
    step();
    check_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 4; i++) add(1'b1, 10'(i), 2'b00, 2'b00, 1'b0, 2'b00);
    run("video");

    for (int i = 0; i < 4; i++) add(1'b0, 10'h0, 2'b11, 2'b00, 1'b0, (i % 2 == 0) ? 2'b01 : 2'b10);
    run("rr");

    add(1'b0, 10'h0,   2'b11, 2'b00, 1'b0, 2'b01);
    add(1'b0, 10'h0,   2'b11, 2'b10, 1'b0, 2'b10);
    add(1'b1, 10'h3C2, 2'b11, 2'b10, 1'b0, 2'b00);
    add(1'b0, 10'h0,   2'b11, 2'b10, 1'b0, 2'b10);
    add(1'b0, 10'h0,   2'b11, 2'b00, 1'b0, 2'b10);
    add(1'b0, 10'h0,   2'b11, 2'b00, 1'b0, 2'b01);
    add(1'b0, 10'h0,   2'b11, 2'b00, 1'b0, 2'b10);
    run("preempt");

`ifdef SPRITE_ARB_BLANK_ONLY_EN
    for (int i = 0; i < 5; i++) add(1'b0, 10'h0, 2'b01, 2'b00, 1'b1, 2'b00);
    add(1'b0, 10'h0, 2'b01, 2'b00, 1'b0, 2'b01);
`else
    add(1'b0, 10'h0, 2'b01, 2'b00, 1'b1, 2'b01);
`endif
    run("blank");

    step();
    aux_req = 2'b10; aux_lock = 2'b10;
    #1;
    check("rst_burst gnt", aux_gnt, 2'b10);
    step();
    reset = 1'b1; vid_req = 1'b1; aux_req = 2'b00; aux_lock = 2'b00;
    step();
    check_zero("rst_mid1");
    step();
    check_zero("rst_mid2");
    reset = 1'b0; vid_req = 1'b0;
    last_addr = '0; last_elem = '0;
    add(1'b0, 10'h0, 2'b11, 2'b00, 1'b0, 2'b01);
    run("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
